load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have port clk_i, input, 1, clock; all state updates on rising edge.
REQ-002 The block SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-003 The block SHALL have port req_valid_i, input, 1, core access request, sampled in IDLE only.
REQ-004 The block SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-005 The block SHALL have port funct3_i, input, 3, RV32I width/sign code.
REQ-006 The block SHALL have port addr_i, input, 32, byte address from ALU.
REQ-007 The block SHALL have port wdata_i, input, 32, store data (rs2).
REQ-008 The block SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-009 The block SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port rdata_o, output, 32, aligned and extended load result.
REQ-011 The block SHALL have port misalign_o, output, 1, misaligned-access flag.
REQ-012 The block SHALL have port mem_req_o, output, 1, memory request.
REQ-013 The block SHALL have port mem_gnt_i, input, 1, memory grant.
REQ-014 The block SHALL have port mem_we_o, output, 1, memory write enable.
REQ-015 The block SHALL have port mem_addr_o, output, 32, word address with bits [1:0] = 0.
REQ-016 The block SHALL have port mem_be_o, output, 4, byte enables.
REQ-017 The block SHALL have port mem_wdata_o, output, 32, lane-replicated store data.
REQ-018 The block SHALL have port mem_rvalid_i, input, 1, read data valid.
REQ-019 The block SHALL have port mem_rdata_i, input, 32, read data.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-021 In IDLE, req_valid_i = 1 SHALL capture we_i, funct3_i, addr_i and wdata_i and move the FSM to REQ; req_valid_i outside IDLE SHALL be ignored.
REQ-022 In REQ, mem_req_o SHALL be 1 and mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o SHALL stay stable until mem_gnt_i = 1.
REQ-023 When a store is granted, the FSM SHALL go REQ -> DONE; when a load is granted, it SHALL go REQ -> WAIT.
REQ-024 In WAIT, mem_rvalid_i = 1 SHALL load rdata_o and move the FSM to DONE; mem_rvalid_i is never asserted in the grant cycle.
REQ-025 In DONE, done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 Minimum latency from req_valid_i to done_o SHALL be 2 cycles for a store and 3 cycles for a load.
REQ-027 Byte enables: SB (000) SHALL give 1 << addr[1:0]; SH (001) SHALL give 0011 when addr[1] = 0, else 1100; SW (010) SHALL give 1111.
REQ-028 Store data: SB SHALL replicate byte [7:0] to all 4 lanes, SH SHALL replicate half [15:0] to both halves, SW SHALL pass the word through.
REQ-029 Load extraction: LB (000) and LH (001) SHALL sign-extend; LBU (100) and LHU (101) SHALL zero-extend the lane selected by addr; LW (010) SHALL pass the full word.
REQ-030 An invalid funct3 (loads 011/110/111, stores 011-111) SHALL issue no memory request, go IDLE -> REQ -> DONE with mem_req_o = 0, and leave rdata_o unchanged.
REQ-031 rdata_o SHALL hold its value until the next load completes; stores SHALL NOT change it.
REQ-032 Without the trap feature, address bits below access size SHALL be ignored: halfword uses addr[1] only, word forces addr[1:0] = 0.

Reset
REQ-033 rstn_i low SHALL immediately force state IDLE, rdata_o = 0, and busy_o, done_o, misalign_o, mem_req_o, mem_we_o = 0, mem_be_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
REQ-034 Reset mid-transaction SHALL abandon the access; a late mem_rvalid_i arriving in IDLE SHALL be ignored.

Configuration
REQ-035 When macro LSU_MISALIGN_TRAP_EN is defined, a halfword access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL go IDLE -> DONE with no memory request, done_o = 1 and misalign_o = 1 in the same cycle, and rdata_o unchanged.
REQ-036 When LSU_MISALIGN_TRAP_EN is undefined, misalign_o SHALL be tied to 0 and REQ-032 SHALL apply.

Verification
REQ-037 SW addr 0x104, wdata 0xDEADBEEF, gnt immediate -> mem_addr_o 0x104, be 1111, done_o at cycle 2.
REQ-038 SB addr 0x103, wdata 0x000000A5 -> be 1000, mem_wdata_o 0xA5A5A5A5.
REQ-039 LB addr 0x201, mem_rdata_i 0x0000F000, rvalid 2 cycles after gnt -> rdata_o 0xFFFFFFF0; LBU same access -> 0x000000F0.
REQ-040 LH addr 0x102, gnt held low 3 cycles -> request fields stable throughout, be 1100, done_o one cycle after rvalid.
REQ-041 Reset asserted in WAIT, then rvalid -> busy_o 0, done_o never asserted, rdata_o 0.
REQ-042 LW addr 0x101 with LSU_MISALIGN_TRAP_EN -> mem_req_o never asserted, done_o and misalign_o at cycle 1; without the macro -> read of 0x100.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit.
// lsu_core_if : pipeline-side access request and load result.
// lsu_mem_if  : word-addressed data-memory request/grant/response bus.
// The LSU connects through core_if.slave and mem_if.master.

interface lsu_core_if;
  logic        req_valid_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misalign_o;

  modport master (
    output req_valid_i, we_i, funct3_i, addr_i, wdata_i,
    input  busy_o, done_o, rdata_o, misalign_o
  );

  modport slave (
    input  req_valid_i, we_i, funct3_i, addr_i, wdata_i,
    output busy_o, done_o, rdata_o, misalign_o
  );
endinterface

interface lsu_mem_if;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, byte-lane steering for
// stores, lane extraction plus sign/zero extension for loads.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses complete immediately with misalign_o instead of touching memory.
// Without it, address bits below the access size are ignored.
//
// state | meaning
// IDLE  | waiting for req_valid_i, request fields captured on accept
// REQ   | mem_req_o held with stable fields until mem_gnt_i (skipped to DONE
//       | with no request when funct3 is invalid)
// WAIT  | load granted, waiting for mem_rvalid_i
// DONE  | one-cycle done_o pulse, then back to IDLE

module load_store_unit (
  input  logic      clk_i,
  input  logic      rstn_i,
  lsu_core_if.slave core_bus,
  lsu_mem_if.master mem_bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_valid;
  logic [31:0] r_rdata;

  logic        w_capture;
  logic        w_valid;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mem_req;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_capture = (r_state == S_IDLE) && core_bus.req_valid_i;

  // Decode the incoming request: legality, lane enables, replicated data.
  always_comb begin
    w_valid = 1'b0;
    w_be    = 4'b1111;
    w_wdata = core_bus.wdata_i;
    case (core_bus.funct3_i)
      3'b000, 3'b001, 3'b010: w_valid = 1'b1;
      3'b100, 3'b101:         w_valid = !core_bus.we_i;
      default:                w_valid = 1'b0;
    endcase
    case (core_bus.funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << core_bus.addr_i[1:0];
        w_wdata = {4{core_bus.wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = core_bus.addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{core_bus.wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = core_bus.wdata_i;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = w_valid &&
                 (((core_bus.funct3_i[1:0] == 2'b01) && core_bus.addr_i[0]) ||
                  ((core_bus.funct3_i[1:0] == 2'b10) && (core_bus.addr_i[1:0] != 2'b00)));
`else
    w_misalign = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic and memory request qualifier.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_bus.req_valid_i) w_state_nxt = w_misalign ? S_DONE : S_REQ;
      end
      S_REQ: begin
        w_mem_req = r_valid;
        if (!r_valid)                  w_state_nxt = S_DONE;
        else if (mem_bus.mem_gnt_i)    w_state_nxt = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_bus.mem_rvalid_i) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Hold the accepted request so the bus fields stay stable until grant.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_valid  <= 1'b0;
    end else if (w_capture) begin
      r_we     <= core_bus.we_i;
      r_funct3 <= core_bus.funct3_i;
      r_addr   <= core_bus.addr_i;
      r_be     <= w_be;
      r_wdata  <= w_wdata;
      r_valid  <= w_valid;
    end
  end

  // Extract the addressed lane and extend it according to funct3.
  always_comb begin
    w_byte = mem_bus.mem_rdata_i[7:0];
    case (r_addr[1:0])
      2'b00: w_byte = mem_bus.mem_rdata_i[7:0];
      2'b01: w_byte = mem_bus.mem_rdata_i[15:8];
      2'b10: w_byte = mem_bus.mem_rdata_i[23:16];
      2'b11: w_byte = mem_bus.mem_rdata_i[31:24];
      default: w_byte = mem_bus.mem_rdata_i[7:0];
    endcase
    w_half = r_addr[1] ? mem_bus.mem_rdata_i[31:16] : mem_bus.mem_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = mem_bus.mem_rdata_i;
    endcase
  end

  // Load result register: only a completing load updates it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                          r_rdata <= '0;
    else if ((r_state == S_WAIT) && mem_bus.mem_rvalid_i) r_rdata <= w_load;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;

  // Remember whether the accepted request trapped, for the DONE flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        r_misalign <= 1'b0;
    else if (w_capture) r_misalign <= w_misalign;
  end

  assign core_bus.misalign_o = (r_state == S_DONE) && r_misalign;
`else
  assign core_bus.misalign_o = 1'b0;
`endif

  assign core_bus.busy_o      = (r_state != S_IDLE);
  assign core_bus.done_o      = (r_state == S_DONE);
  assign core_bus.rdata_o     = r_rdata;

  assign mem_bus.mem_req_o    = w_mem_req;
  assign mem_bus.mem_we_o     = w_mem_req && r_we;
  assign mem_bus.mem_addr_o   = w_mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_bus.mem_be_o     = w_mem_req ? r_be : 4'b0000;
  assign mem_bus.mem_wdata_o  = w_mem_req ? r_wdata : 32'h0;

endmodule
